// File: rtl/arp_rx_parser.sv
// rtl/arp_rx_parser.sv - ARP payload parser issuing ARP-table updates and reply requests
module arp_rx_parser #(
  parameter bit P_UPDATE_ANY = 1'b0,
  parameter int P_MIN_LEN    = 28
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_local_ip,
  input  logic [7:0]  i_arp_data,
  input  logic        i_arp_valid,
  input  logic        i_arp_last,
  output logic [31:0] o_updata_ip,
  output logic [47:0] o_updata_mac,
  output logic        o_updata_valid,
  output logic [31:0] o_reply_ip,
  output logic [47:0] o_reply_mac,
  output logic        o_reply_valid,
  output logic        o_err
);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_PAD, S_DROP} state_t;

  // Index of the last beat of the shortest acceptable frame.
  localparam logic [6:0] LP_MIN_IDX = 7'(P_MIN_LEN - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_idx;
  logic        r_hdr_ok;
  logic [15:0] r_oper;
  logic [47:0] r_sha;
  logic [31:0] r_spa;
  logic [31:0] r_tpa;

  logic        w_byte_bad;
  logic        w_len_ok;
  logic [31:0] w_tpa_now;
  logic        w_match;
  logic        w_eval;
  logic        w_err_nxt;
  logic        w_upd_nxt;
  logic        w_rep_nxt;

  // Compare the current byte against the fixed Ethernet/IPv4 ARP header.
  always_comb begin
    w_byte_bad = 1'b0;
    case (r_idx)
      6'd0:    w_byte_bad = (i_arp_data != 8'h00);
      6'd1:    w_byte_bad = (i_arp_data != 8'h01);
      6'd2:    w_byte_bad = (i_arp_data != 8'h08);
      6'd3:    w_byte_bad = (i_arp_data != 8'h00);
      6'd4:    w_byte_bad = (i_arp_data != 8'h06);
      6'd5:    w_byte_bad = (i_arp_data != 8'h04);
      6'd6:    w_byte_bad = (i_arp_data != 8'h00);
      6'd7:    w_byte_bad = (i_arp_data != 8'h01) && (i_arp_data != 8'h02);
      default: w_byte_bad = 1'b0;
    endcase
  end

  // TPA completes on idx 27, so fold in the live byte when evaluating on that beat.
  assign w_tpa_now = (r_idx == 6'd27) ? {r_tpa[23:0], i_arp_data} : r_tpa;
  assign w_match   = (w_tpa_now == i_local_ip);
  assign w_len_ok  = ({1'b0, r_idx} >= LP_MIN_IDX);

  // Byte counter and header-ok flag; both rearm on every last beat for zero-gap frames.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx    <= 6'd0;
      r_hdr_ok <= 1'b1;
    end else if (i_arp_valid) begin
      if (i_arp_last) begin
        r_idx    <= 6'd0;
        r_hdr_ok <= 1'b1;
      end else begin
        if (r_idx != 6'd63) r_idx <= r_idx + 6'd1;
        if (w_byte_bad) r_hdr_ok <= 1'b0;
      end
    end
  end

  // Shift the big-endian OPER/SHA/SPA/TPA fields in MSB first; THA is skipped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_oper <= 16'd0;
      r_sha  <= 48'd0;
      r_spa  <= 32'd0;
      r_tpa  <= 32'd0;
    end else if (i_arp_valid) begin
      if (r_idx == 6'd6 || r_idx == 6'd7)   r_oper <= {r_oper[7:0], i_arp_data};
      if (r_idx >= 6'd8 && r_idx <= 6'd13)  r_sha  <= {r_sha[39:0], i_arp_data};
      if (r_idx >= 6'd14 && r_idx <= 6'd17) r_spa  <= {r_spa[23:0], i_arp_data};
      if (r_idx >= 6'd24 && r_idx <= 6'd27) r_tpa  <= {r_tpa[23:0], i_arp_data};
    end
  end

  // Frame state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; decides on each last beat whether to evaluate or discard.
  always_comb begin
    w_state_nxt = r_state;
    w_eval      = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_arp_valid) begin
          if (i_arp_last)      w_err_nxt   = 1'b1;
          else if (w_byte_bad) w_state_nxt = S_DROP;
          else                 w_state_nxt = S_RECV;
        end
      end
      S_RECV: begin
        if (i_arp_valid) begin
          if (w_byte_bad) begin
            if (i_arp_last) begin
              w_err_nxt   = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_DROP;
            end
          end else if (i_arp_last) begin
            w_state_nxt = S_IDLE;
            if (r_idx == 6'd27 && w_len_ok) w_eval    = 1'b1;
            else                            w_err_nxt = 1'b1;
          end else if (r_idx == 6'd27) begin
            w_state_nxt = S_PAD;
          end
        end
      end
      S_PAD: begin
        if (i_arp_valid && i_arp_last) begin
          w_state_nxt = S_IDLE;
          if (w_len_ok) w_eval    = 1'b1;
          else          w_err_nxt = 1'b1;
        end
      end
      S_DROP: begin
        if (i_arp_valid && i_arp_last) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // An all-zero SPA is an ARP probe: never learned, but still answered.
  assign w_upd_nxt = w_eval && r_hdr_ok && (w_match || P_UPDATE_ANY) && (r_spa != 32'd0);
  assign w_rep_nxt = w_eval && r_hdr_ok && w_match && (r_oper == 16'h0001);

  // Register strobes one cycle after the last beat; data holds between strobes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_updata_ip    <= 32'd0;
      o_updata_mac   <= 48'd0;
      o_updata_valid <= 1'b0;
      o_reply_ip     <= 32'd0;
      o_reply_mac    <= 48'd0;
      o_reply_valid  <= 1'b0;
      o_err          <= 1'b0;
    end else begin
      o_updata_valid <= w_upd_nxt;
      o_reply_valid  <= w_rep_nxt;
      o_err          <= w_err_nxt;
      if (w_upd_nxt) begin
        o_updata_ip  <= r_spa;
        o_updata_mac <= r_sha;
      end
      if (w_rep_nxt) begin
        o_reply_ip  <= r_spa;
        o_reply_mac <= r_sha;
      end
    end
  end

endmodule

// File: tb/tb_arp_rx_parser.sv
// tb/tb_arp_rx_parser.sv - self-checking bench for arp_rx_parser (both update modes)
module tb_arp_rx_parser;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_local_ip = 32'hC0A8010A;
  logic [7:0]  i_arp_data = 8'd0;
  logic        i_arp_valid = 1'b0;
  logic        i_arp_last = 1'b0;

  logic [31:0] uip0, rip0, uip1, rip1;
  logic [47:0] umac0, rmac0, umac1, rmac1;
  logic        uv0, rv0, er0, uv1, rv1, er1;

  arp_rx_parser #(.P_UPDATE_ANY(1'b0), .P_MIN_LEN(28)) u_dut0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_local_ip(i_local_ip),
    .i_arp_data(i_arp_data), .i_arp_valid(i_arp_valid), .i_arp_last(i_arp_last),
    .o_updata_ip(uip0), .o_updata_mac(umac0), .o_updata_valid(uv0),
    .o_reply_ip(rip0), .o_reply_mac(rmac0), .o_reply_valid(rv0), .o_err(er0));

  arp_rx_parser #(.P_UPDATE_ANY(1'b1), .P_MIN_LEN(28)) u_dut1 (
    .i_clk(i_clk), .i_rst(i_rst), .i_local_ip(i_local_ip),
    .i_arp_data(i_arp_data), .i_arp_valid(i_arp_valid), .i_arp_last(i_arp_last),
    .o_updata_ip(uip1), .o_updata_mac(umac1), .o_updata_valid(uv1),
    .o_reply_ip(rip1), .o_reply_mac(rmac1), .o_reply_valid(rv1), .o_err(er1));

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          upd0;
    bit          upd1;
    bit          rep;
    bit          err;
    logic [31:0] ip;
    logic [47:0] mac;
  } exp_t;

  typedef struct {
    logic [15:0] ptype;
    logic [15:0] oper;
    logic [31:0] spa;
    logic [31:0] tpa;
    int          len;
    int          gap;
    bit          upd0;
    bit          upd1;
    bit          rep;
    bit          err;
  } vec_t;

  exp_t exp_by_cyc [int];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Cycle-exact scoreboard: every cycle out of reset, strobes must match the expectation for that cycle.
  always @(negedge i_clk) begin
    exp_t e;
    if (!i_rst) begin
      e = '{default: '0};
      if (exp_by_cyc.exists(cyc)) begin
        e = exp_by_cyc[cyc];
        exp_by_cyc.delete(cyc);
      end
      check("dut0_strobes", 80'({uv0, rv0, er0}), 80'({e.upd0, e.rep, e.err}));
      check("dut1_strobes", 80'({uv1, rv1, er1}), 80'({e.upd1, e.rep, e.err}));
      if (e.upd0) check("dut0_upd_data", {umac0, uip0}, {e.mac, e.ip});
      if (e.upd1) check("dut1_upd_data", {umac1, uip1}, {e.mac, e.ip});
      if (e.rep) begin
        check("dut0_rep_data", {rmac0, rip0}, {e.mac, e.ip});
        check("dut1_rep_data", {rmac1, rip1}, {e.mac, e.ip});
      end
    end
  end

  function automatic void build(output logic [7:0] q[$], input logic [15:0] ptype,
                                input logic [15:0] oper, input logic [47:0] sha,
                                input logic [31:0] spa, input logic [31:0] tpa, input int len);
    logic [7:0] b [28];
    b[0] = 8'h00; b[1] = 8'h01; b[2] = ptype[15:8]; b[3] = ptype[7:0];
    b[4] = 8'h06; b[5] = 8'h04; b[6] = oper[15:8];  b[7] = oper[7:0];
    for (int i = 0; i < 6; i++) b[8 + i]  = sha[47 - 8*i -: 8];
    for (int i = 0; i < 4; i++) b[14 + i] = spa[31 - 8*i -: 8];
    for (int i = 0; i < 6; i++) b[18 + i] = 8'($urandom);
    for (int i = 0; i < 4; i++) b[24 + i] = tpa[31 - 8*i -: 8];
    q = {};
    for (int i = 0; i < len; i++) q.push_back(i < 28 ? b[i] : 8'($urandom));
  endfunction

  // Reference: judge the whole frame at once from its byte list.
  function automatic exp_t model(input logic [7:0] q[$], input logic [31:0] lip);
    exp_t e;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa, tpa;
    bit hdr, match;
    e = '{default: '0};
    if (q.size() < 28) begin
      e.err = 1'b1;
      return e;
    end
    oper = {q[6], q[7]};
    hdr = ({q[0], q[1]} == 16'h0001) && ({q[2], q[3]} == 16'h0800) &&
          (q[4] == 8'h06) && (q[5] == 8'h04) && (oper == 16'd1 || oper == 16'd2);
    if (!hdr) begin
      e.err = 1'b1;
      return e;
    end
    sha = '0; spa = '0; tpa = '0;
    for (int i = 8; i < 14; i++)  sha = (sha << 8) | 48'(q[i]);
    for (int i = 14; i < 18; i++) spa = (spa << 8) | 32'(q[i]);
    for (int i = 24; i < 28; i++) tpa = (tpa << 8) | 32'(q[i]);
    match  = (tpa == lip);
    e.upd0 = match && (spa != 0);
    e.upd1 = (spa != 0);
    e.rep  = match && (oper == 16'd1);
    e.ip   = spa;
    e.mac  = sha;
    return e;
  endfunction

  task automatic send(input logic [7:0] q[$], input int gap, input bit with_last, input exp_t e);
    for (int i = 0; i < q.size(); i++) begin
      while (int'($urandom_range(99)) < gap) begin
        i_arp_valid = 1'b0;
        i_arp_last  = 1'b0;
        @(posedge i_clk); #1;
      end
      i_arp_valid = 1'b1;
      i_arp_data  = q[i];
      i_arp_last  = with_last && (i == q.size() - 1);
      if (i_arp_last) exp_by_cyc[cyc + 1] = e;
      @(posedge i_clk); #1;
    end
    i_arp_valid = 1'b0;
    i_arp_last  = 1'b0;
  endtask

  task automatic check_reset();
    check("rst_strobes", 80'({uv0, rv0, er0, uv1, rv1, er1}), 80'd0);
    check("rst_dut0_upd", {umac0, uip0}, 80'd0);
    check("rst_dut0_rep", {rmac0, rip0}, 80'd0);
    check("rst_dut1_upd", {umac1, uip1}, 80'd0);
    check("rst_dut1_rep", {rmac1, rip1}, 80'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  localparam logic [47:0] SHA = 48'h001122334455;
  localparam logic [31:0] LIP = 32'hC0A8010A;
  localparam logic [31:0] SPA = 32'hC0A80102;

  initial begin
    vec_t       vecs [13];
    logic [7:0] q[$];
    logic [7:0] qp[$];
    exp_t       e;
    logic [31:0] lip, spa, tpa;
    logic [47:0] sha;
    logic [15:0] oper, ptype;
    int         len, gap, r;

    //           ptype     oper   spa    tpa            len gap upd0 upd1 rep err
    vecs[0]  = '{16'h0800, 16'd1, SPA,   LIP,           28, 0,  1,   1,   1,  0};
    vecs[1]  = '{16'h0800, 16'd2, SPA,   LIP,           46, 0,  1,   1,   0,  0};
    vecs[2]  = '{16'h0800, 16'd1, SPA,   32'hC0A80163,  28, 0,  0,   1,   0,  0};
    vecs[3]  = '{16'h86DD, 16'd1, SPA,   LIP,           28, 0,  0,   0,   0,  1};
    vecs[4]  = '{16'h0800, 16'd1, SPA,   LIP,           20, 0,  0,   0,   0,  1};
    vecs[5]  = '{16'h0800, 16'd1, SPA,   LIP,           28, 0,  1,   1,   1,  0};
    vecs[6]  = '{16'h0800, 16'd1, SPA,   LIP,           28, 50, 1,   1,   1,  0};
    vecs[7]  = '{16'h0800, 16'd1, 32'd0, LIP,           28, 0,  0,   0,   1,  0};
    vecs[8]  = '{16'h0800, 16'd3, SPA,   LIP,           28, 0,  0,   0,   0,  1};
    vecs[9]  = '{16'h0800, 16'd2, SPA,   LIP,           70, 0,  1,   1,   0,  0};
    vecs[10] = '{16'h0800, 16'd1, SPA,   LIP,           27, 0,  0,   0,   0,  1};
    vecs[11] = '{16'h0800, 16'd1, SPA,   LIP,           1,  0,  0,   0,   0,  1};
    vecs[12] = '{16'h0800, 16'd2, SPA,   32'h0A000001,  28, 0,  0,   1,   0,  0};

    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_reset();
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    @(posedge i_clk); #1;

    // Directed table, frames sent back to back with zero gap between them.
    i_local_ip = LIP;
    for (int v = 0; v < 13; v++) begin
      build(q, vecs[v].ptype, vecs[v].oper, SHA, vecs[v].spa, vecs[v].tpa, vecs[v].len);
      e = '{upd0: vecs[v].upd0, upd1: vecs[v].upd1, rep: vecs[v].rep, err: vecs[v].err,
            ip: vecs[v].spa, mac: SHA};
      send(q, vecs[v].gap, 1'b1, e);
    end
    repeat (3) @(posedge i_clk); #1;

    // Reset in the middle of a frame, then a clean frame.
    build(q, 16'h0800, 16'd1, SHA, SPA, LIP, 28);
    qp = q[0:11];
    send(qp, 0, 1'b0, '{default: '0});
    i_rst = 1'b1;
    @(negedge i_clk);
    check_reset();
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    send(q, 0, 1'b1, '{upd0: 1, upd1: 1, rep: 1, err: 0, ip: SPA, mac: SHA});
    repeat (3) @(posedge i_clk); #1;

    // Randomized frames against the reference model.
    for (int n = 0; n < 60; n++) begin
      lip   = $urandom;
      r     = int'($urandom_range(9));
      oper  = (r == 0) ? 16'd3 : (r < 6) ? 16'd1 : 16'd2;
      ptype = ($urandom_range(9) == 0) ? 16'h86DD : 16'h0800;
      tpa   = ($urandom_range(1) == 1) ? lip : $urandom;
      spa   = ($urandom_range(5) == 0) ? 32'd0 : $urandom;
      sha   = {16'($urandom), $urandom};
      len   = ($urandom_range(5) == 0) ? int'($urandom_range(27, 1)) : int'($urandom_range(80, 28));
      gap   = ($urandom_range(1) == 1) ? 0 : 50;
      build(q, ptype, oper, sha, spa, tpa, len);
      if ($urandom_range(14) == 0 && len > 6) begin
        r = int'($urandom_range(5));
        q[r] = q[r] ^ 8'h10;
      end
      i_local_ip = lip;
      e = model(q, lip);
      send(q, gap, 1'b1, e);
    end

    repeat (4) @(posedge i_clk); #1;
    check("pending_expectations", 80'(exp_by_cyc.size()), 80'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
